dram_line_cache: RTL and testbench
==================================

// Module: dram_line_cache
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate read cache between the RISC-V core and the
//  non-cached DRAM controller. Serves 32-bit core loads from 128-bit lines. On a miss it issues
//  one line read to the controller. Every store is forwarded as a single masked word write.
//  Read hits return in 1 cycle instead of a full clock-domain-crossing DRAM round trip.
// PARAMETERS
//  NUM_LINES   16  cache lines, power of two, >= 2
//  ADDR_WIDTH  27  byte-address bits decoded for DRAM; tag = ADDR_WIDTH-4-log2(NUM_LINES) bits
// PORTS
//  i_clk          in   1    single clock (same clock as the controller's o_clk)
//  i_rst          in   1    reset, asynchronous, active-high
//  i_rd_en        in   1    core load request; accepted only when o_busy==0
//  i_wr_en        in   1    core store request; accepted only when o_busy==0; wins over i_rd_en
//  i_addr         in   32   byte address; [3:2] selects the word; [1:0] ignored
//  i_wdata        in   32   store data
//  i_wstrb        in   4    store byte enables, 1 = write byte
//  i_flush        in   1    invalidate all lines
//  o_rdata        out  32   load data, valid while o_rvalid
//  o_rvalid       out  1    1-cycle pulse per completed load
//  o_busy         out  1    1 = not accepting requests
//  o_dram_rd_en   out  1    1-cycle read pulse to the controller
//  o_dram_wr_en   out  1    1-cycle write pulse to the controller
//  o_dram_addr    out  32   reads: {i_addr[31:4],4'b0}; writes: {i_addr[31:2],2'b0}
//  o_dram_wdata   out  32   store data
//  o_dram_mask    out  4    ~i_wstrb, 1 = byte NOT written
//  i_dram_rdata   in   128  line data from the controller
//  i_dram_busy    in   1    controller busy (also high during calibration)
// BEHAVIOUR
//  Reset: state=IDLE, all valid bits=0, every output=0 (o_busy=0). Tag/data arrays are not reset.
//  States:
//    IDLE: request accepted on a posedge with o_busy==0.
//      Store        -> WR_ISSUE.
//      Load hit     -> stay IDLE; o_rvalid=1 and o_rdata=word[addr[3:2]] next cycle.
//      Load miss    -> RD_ISSUE.
//    RD_ISSUE/WR_ISSUE: entered only when i_dram_busy==0; otherwise wait in IDLE-with-busy.
//      Assert o_dram_*_en for exactly 1 cycle, then go to RD_WAIT/WR_WAIT unconditionally.
//      The controller samples on negedge, so i_dram_busy is high at the next posedge.
//    RD_WAIT: on the first cycle with i_dram_busy==0:
//      - capture i_dram_rdata into the line; set valid; write the tag.
//      - next cycle o_rvalid=1 with word[addr[3:2]]; -> IDLE.
//    WR_WAIT: on i_dram_busy==0 -> IDLE. No o_rvalid for stores.
//  o_busy: 1 in every state except IDLE. It also stays 1 in IDLE while i_dram_busy==1 with a
//    miss or store pending. The request is latched at acceptance; core inputs are don't-care
//    while busy.
//  Store hit: merge bytes into the cached line in the accept cycle (byte lane = addr[3:2]*4+i).
//  Store miss: no line change.
//  Line index = addr[log2(NUM_LINES)+3:4]; tag = addr[ADDR_WIDTH-1:log2(NUM_LINES)+4].
//  Hit = valid[idx] && tag match.
//  i_flush: clears all valid bits on the next posedge. Ignored while RD_WAIT is pending.
//    In that case it is applied after the fill, so the fill is also invalidated.
//  Simultaneous rd+wr: the store is taken; the load is dropped, and the core re-issues it.
//  Load to the line of an outstanding store: impossible, because stores block until WR_WAIT exits.
//  Reset mid-operation: state and valid bits are cleared immediately. A controller transaction
//    already in flight completes and is discarded. The next issue waits for i_dram_busy==0.
// STRUCTURE
//  State encodings and the line/word width constants go in define.vh.
//  Sub-module dram_cache_array holds the tag, valid and data storage:
//    - async read on the index;
//    - sync line write with 16-bit byte enables;
//    - 1-cycle valid clear.
//  dram_line_cache holds the FSM, hit compare, word select and DRAM pulse generation.
// TESTING
//  The bench models the controller: busy rises at the negedge of the pulse and falls N=6 cycles
//  later. rdata = f(addr).
//  1 Cold load 0x0000_1004 -> one o_dram_rd_en, addr 0x0000_1000; then o_rvalid with word1 of
//    the line; o_busy low after.
//  2 Reload 0x0000_1008 -> no DRAM pulse; o_rvalid the next cycle with word2; o_busy stays 0.
//  3 Store 0xAABBCCDD, wstrb 4'b0011, to 0x0000_1008 -> o_dram_mask=4'b1100, addr 0x0000_1008.
//    Then load 0x0000_1008 -> hit, returns {old[31:16],16'hCCDD}.
//  4 Load 0x0000_1100 (same index, different tag) -> miss and refill. Then load 0x0000_1000 ->
//    miss again.
//  5 Hold i_dram_busy=1 for 50 cycles (calibration), then load -> no pulse until busy drops;
//    o_busy=1 throughout.
//  6 Assert i_rst during RD_WAIT -> outputs 0 at once, all lines invalid. Prior hit addresses miss.

Source files
------------

// File: rtl/dram_line_cache_pkg.sv
// Shared types and constants for the DRAM line cache: FSM states, latched request, line geometry.
package dram_line_cache_pkg;

  localparam int unsigned DEF_NUM_LINES  = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 27;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LINE_W         = 128;
  localparam int unsigned LINE_BYTES     = LINE_W / 8;
  localparam int unsigned STRB_W         = WORD_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE,
    ST_WR_WAIT
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [31:0]       addr;
    logic [WORD_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  // Select one 32-bit word of a line by byte-address bits [3:2]
  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [1:0]        sel);
    return WORD_W'(line >> {sel, 5'd0});
  endfunction

endpackage

// File: rtl/dram_line_cache_if.sv
// Core request/response and DRAM controller signals of the line cache, grouped as one bus.
interface dram_line_cache_if;
  import dram_line_cache_pkg::*;

  logic                i_rd_en;
  logic                i_wr_en;
  logic [31:0]         i_addr;
  logic [WORD_W-1:0]   i_wdata;
  logic [STRB_W-1:0]   i_wstrb;
  logic                i_flush;
  logic [WORD_W-1:0]   o_rdata;
  logic                o_rvalid;
  logic                o_busy;
  logic                o_dram_rd_en;
  logic                o_dram_wr_en;
  logic [31:0]         o_dram_addr;
  logic [WORD_W-1:0]   o_dram_wdata;
  logic [STRB_W-1:0]   o_dram_mask;
  logic [LINE_W-1:0]   i_dram_rdata;
  logic                i_dram_busy;

  modport slave (
    input  i_rd_en, i_wr_en, i_addr, i_wdata, i_wstrb, i_flush, i_dram_rdata, i_dram_busy,
    output o_rdata, o_rvalid, o_busy, o_dram_rd_en, o_dram_wr_en, o_dram_addr, o_dram_wdata,
           o_dram_mask
  );

  modport master (
    output i_rd_en, i_wr_en, i_addr, i_wdata, i_wstrb, i_flush, i_dram_rdata, i_dram_busy,
    input  o_rdata, o_rvalid, o_busy, o_dram_rd_en, o_dram_wr_en, o_dram_addr, o_dram_wdata,
           o_dram_mask
  );

endinterface

// File: rtl/dram_line_cache_array.sv
// Tag/valid/data storage: async read by index, byte-enabled line write, single-cycle valid clear.
module dram_line_cache_array
  import dram_line_cache_pkg::*;
#(
  parameter int unsigned NUM_LINES = DEF_NUM_LINES,
  parameter int unsigned TAG_W     = 19
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [$clog2(NUM_LINES)-1:0] i_rd_idx,
  output logic                         o_valid,
  output logic [TAG_W-1:0]             o_tag,
  output logic [LINE_W-1:0]            o_line,
  input  logic                         i_we,
  input  logic [$clog2(NUM_LINES)-1:0] i_wr_idx,
  input  logic [LINE_BYTES-1:0]        i_wr_be,
  input  logic [LINE_W-1:0]            i_wr_line,
  input  logic [TAG_W-1:0]             i_wr_tag,
  input  logic                         i_set_valid,
  input  logic                         i_clr
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign o_valid = valid_q[i_rd_idx];
  assign o_tag   = tag_q[i_rd_idx];
  assign o_line  = data_q[i_rd_idx];

  // Clear has priority so a flush always wins over a same-cycle fill
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= '0;
    end else if (i_clr) begin
      valid_q <= '0;
    end else if (i_we && i_set_valid) begin
      valid_q[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      if (i_set_valid) begin
        tag_q[i_wr_idx] <= i_wr_tag;
      end
      for (int b = 0; b < int'(LINE_BYTES); b++) begin
        if (i_wr_be[b]) begin
          data_q[i_wr_idx][b*8 +: 8] <= i_wr_line[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dram_line_cache.sv
// Direct-mapped write-through read cache in front of the DRAM controller: FSM, hit compare,
// word select and single-cycle DRAM read/write pulse generation.
module dram_line_cache
  import dram_line_cache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst,
  dram_line_cache_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_WIDTH - 4 - IDX_W;

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic              pend_q, pend_d;
  logic              flush_pend_q, flush_pend_d;
  logic              busy_q, busy_d;
  logic              rvalid_q, rvalid_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              dram_rd_en_q, dram_rd_en_d;
  logic              dram_wr_en_q, dram_wr_en_d;
  logic [31:0]       dram_addr_q, dram_addr_d;
  logic [WORD_W-1:0] dram_wdata_q, dram_wdata_d;
  logic [STRB_W-1:0] dram_mask_q, dram_mask_d;

  req_t              new_req, src_req;
  logic              accept, hit, launch, fill, rd_inflight;
  logic              arr_we, arr_clr, arr_valid;
  logic [TAG_W-1:0]  arr_tag;
  logic [LINE_W-1:0] arr_line, arr_wr_line;
  logic [LINE_BYTES-1:0] arr_wr_be;
  logic [IDX_W-1:0]  arr_wr_idx;
  logic              unused_addr_lsb;

  assign new_req     = '{wr: bus.i_wr_en, addr: bus.i_addr, wdata: bus.i_wdata,
                         wstrb: bus.i_wstrb};
  assign accept      = !busy_q && (bus.i_rd_en || bus.i_wr_en);
  assign hit         = arr_valid && (arr_tag == bus.i_addr[ADDR_WIDTH-1:IDX_W+4]);
  assign fill        = (state_q == ST_RD_WAIT) && !bus.i_dram_busy;
  assign rd_inflight = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT);

  // Line writes come either from a fill or from a store hit in its accept cycle
  assign arr_we      = fill || (accept && bus.i_wr_en && hit);
  assign arr_wr_idx  = fill ? req_q.addr[IDX_W+3:4] : bus.i_addr[IDX_W+3:4];
  assign arr_wr_line = fill ? bus.i_dram_rdata : {4{bus.i_wdata}};
  assign arr_wr_be   = fill ? '1 : (LINE_BYTES'(bus.i_wstrb) << {bus.i_addr[3:2], 2'b00});
  assign arr_clr     = (bus.i_flush && !rd_inflight) || flush_pend_q;
  assign unused_addr_lsb = ^req_q.addr[1:0];

  dram_line_cache_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W)
  ) u_array (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rd_idx    (bus.i_addr[IDX_W+3:4]),
    .o_valid     (arr_valid),
    .o_tag       (arr_tag),
    .o_line      (arr_line),
    .i_we        (arr_we),
    .i_wr_idx    (arr_wr_idx),
    .i_wr_be     (arr_wr_be),
    .i_wr_line   (arr_wr_line),
    .i_wr_tag    (req_q.addr[ADDR_WIDTH-1:IDX_W+4]),
    .i_set_valid (fill),
    .i_clr       (arr_clr)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    pend_d       = pend_q;
    rvalid_d     = 1'b0;
    rdata_d      = rdata_q;
    dram_rd_en_d = 1'b0;
    dram_wr_en_d = 1'b0;
    dram_addr_d  = dram_addr_q;
    dram_wdata_d = dram_wdata_q;
    dram_mask_d  = dram_mask_q;
    launch       = 1'b0;
    src_req      = req_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d   = new_req;
          src_req = new_req;
          if (new_req.wr || !hit) begin
            launch = 1'b1;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = word_sel(arr_line, bus.i_addr[3:2]);
          end
        end else if (pend_q) begin
          launch = 1'b1;
        end
        // Issue only into an idle controller; otherwise hold the request with busy set
        if (launch) begin
          if (bus.i_dram_busy) begin
            pend_d = 1'b1;
          end else begin
            pend_d = 1'b0;
            if (src_req.wr) begin
              state_d      = ST_WR_ISSUE;
              dram_wr_en_d = 1'b1;
              dram_addr_d  = {src_req.addr[31:2], 2'b00};
              dram_wdata_d = src_req.wdata;
              dram_mask_d  = ~src_req.wstrb;
            end else begin
              state_d      = ST_RD_ISSUE;
              dram_rd_en_d = 1'b1;
              dram_addr_d  = {src_req.addr[31:4], 4'b0000};
            end
          end
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_WR_ISSUE: state_d = ST_WR_WAIT;
      ST_RD_WAIT: begin
        if (!bus.i_dram_busy) begin
          rvalid_d = 1'b1;
          rdata_d  = word_sel(bus.i_dram_rdata, req_q.addr[3:2]);
          state_d  = ST_IDLE;
        end
      end
      ST_WR_WAIT: begin
        if (!bus.i_dram_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A flush seen during a line read is replayed once the fill has landed
    flush_pend_d = rd_inflight ? (flush_pend_q || bus.i_flush) : 1'b0;
    busy_d       = (state_d != ST_IDLE) || pend_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      pend_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      dram_rd_en_q <= 1'b0;
      dram_wr_en_q <= 1'b0;
      dram_addr_q  <= '0;
      dram_wdata_q <= '0;
      dram_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      pend_q       <= pend_d;
      flush_pend_q <= flush_pend_d;
      busy_q       <= busy_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      dram_rd_en_q <= dram_rd_en_d;
      dram_wr_en_q <= dram_wr_en_d;
      dram_addr_q  <= dram_addr_d;
      dram_wdata_q <= dram_wdata_d;
      dram_mask_q  <= dram_mask_d;
    end
  end

  assign bus.o_rdata      = rdata_q;
  assign bus.o_rvalid     = rvalid_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_dram_rd_en = dram_rd_en_q;
  assign bus.o_dram_wr_en = dram_wr_en_q;
  assign bus.o_dram_addr  = dram_addr_q;
  assign bus.o_dram_wdata = dram_wdata_q;
  assign bus.o_dram_mask  = dram_mask_q;

endmodule

// File: tb/tb_dram_line_cache.sv
// Directed bench for dram_line_cache with a behavioural DRAM controller and a load scoreboard.
module tb_dram_line_cache;
  import dram_line_cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_line_cache_if bus ();

  dram_line_cache #(
    .NUM_LINES  (16),
    .ADDR_WIDTH (27)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wmem[logic [31:0]];
  int          rd_pulses = 0;
  int          wr_pulses = 0;
  logic [31:0] last_rd_addr = '0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic [3:0]  last_wr_mask = '0;
  logic        ctl_busy = 1'b0;
  logic        cal_busy = 1'b0;
  int          ctl_cnt = 0;

  assign bus.i_dram_busy = ctl_busy | cal_busy;

  function automatic logic [31:0] base_word(input logic [31:0] a);
    return {a[15:2], 2'b01, ~a[15:2], 2'b10};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (wmem.exists(k)) return wmem[k];
    return base_word(k);
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = mem_word({a[31:4], 4'b0000} + 32'(k * 4));
    return l;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model: busy rises at the pulse negedge, drops 6 cycles later
  always @(negedge clk) begin
    if (bus.o_dram_rd_en === 1'b1) begin
      bus.i_dram_rdata = line_of(bus.o_dram_addr);
      ctl_busy = 1'b1;
      ctl_cnt  = 6;
    end else if (bus.o_dram_wr_en === 1'b1) begin
      logic [31:0] k, w;
      k = {bus.o_dram_addr[31:2], 2'b00};
      w = mem_word(k);
      for (int b = 0; b < 4; b++)
        if (!bus.o_dram_mask[b]) w[b*8 +: 8] = bus.o_dram_wdata[b*8 +: 8];
      wmem[k]  = w;
      ctl_busy = 1'b1;
      ctl_cnt  = 6;
    end else if (ctl_cnt > 0) begin
      ctl_cnt--;
      if (ctl_cnt == 0) ctl_busy = 1'b0;
    end
  end

  // Monitor: pulse bookkeeping and scoreboard compare of every returned load
  always @(negedge clk) begin
    if (bus.o_dram_rd_en === 1'b1) begin
      rd_pulses++;
      last_rd_addr = bus.o_dram_addr;
    end
    if (bus.o_dram_wr_en === 1'b1) begin
      wr_pulses++;
      last_wr_addr = bus.o_dram_addr;
      last_wr_data = bus.o_dram_wdata;
      last_wr_mask = bus.o_dram_mask;
    end
    if (bus.o_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", 128'(bus.o_rvalid), 128'(0));
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("rdata", 128'(bus.o_rdata), 128'(e));
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 300 && bus.o_busy !== 1'b0; i++) @(negedge clk);
    chk("ready_timeout", 128'(bus.o_busy), 128'(0));
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || bus.o_busy !== 1'b0); i++) @(negedge clk);
    chk("drain_timeout", 128'({exp_q.size() == 0, bus.o_busy}), 128'(2'b10));
  endtask

  task automatic load(input logic [31:0] a);
    wait_ready();
    bus.i_rd_en = 1'b1;
    bus.i_addr  = a;
    exp_q.push_back(mem_word(a));
    @(negedge clk);
    bus.i_rd_en = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wait_ready();
    bus.i_wr_en = 1'b1;
    bus.i_addr  = a;
    bus.i_wdata = d;
    bus.i_wstrb = s;
    @(negedge clk);
    bus.i_wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, w0;
    logic [31:0] old;
    bus.i_rd_en = 1'b0;
    bus.i_wr_en = 1'b0;
    bus.i_addr  = '0;
    bus.i_wdata = '0;
    bus.i_wstrb = '0;
    bus.i_flush = 1'b0;
    bus.i_dram_rdata = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy",   128'(bus.o_busy), 128'(0));
    chk("rst_rvalid", 128'(bus.o_rvalid), 128'(0));
    chk("rst_rd_en",  128'(bus.o_dram_rd_en), 128'(0));
    chk("rst_wr_en",  128'(bus.o_dram_wr_en), 128'(0));
    chk("rst_rdata",  128'(bus.o_rdata), 128'(0));
    chk("rst_addr",   128'(bus.o_dram_addr), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Cold load
    p0 = rd_pulses;
    load(32'h0000_1004);
    drain();
    chk("t1_rd_pulses", 128'(rd_pulses - p0), 128'(1));
    chk("t1_rd_addr", 128'(last_rd_addr), 128'(32'h0000_1000));
    chk("t1_busy_after", 128'(bus.o_busy), 128'(0));

    // Hit in the same line
    p0 = rd_pulses;
    load(32'h0000_1008);
    chk("t2_rvalid_next", 128'(bus.o_rvalid), 128'(1));
    chk("t2_busy_low", 128'(bus.o_busy), 128'(0));
    drain();
    chk("t2_no_pulse", 128'(rd_pulses - p0), 128'(0));

    // Partial store hit, then read back the merged word
    old = base_word(32'h0000_1008);
    w0 = wr_pulses;
    store(32'h0000_1008, 32'hAABB_CCDD, 4'b0011);
    drain();
    chk("t3_wr_pulses", 128'(wr_pulses - w0), 128'(1));
    chk("t3_wr_addr", 128'(last_wr_addr), 128'(32'h0000_1008));
    chk("t3_wr_mask", 128'(last_wr_mask), 128'(4'b1100));
    chk("t3_wr_data", 128'(last_wr_data), 128'(32'hAABB_CCDD));
    p0 = rd_pulses;
    load(32'h0000_1008);
    chk("t3_merge", 128'(bus.o_rdata), 128'({old[31:16], 16'hCCDD}));
    drain();
    chk("t3_hit_no_pulse", 128'(rd_pulses - p0), 128'(0));

    // Conflict miss on the same index
    p0 = rd_pulses;
    load(32'h0000_1100);
    drain();
    chk("t4_miss1", 128'(rd_pulses - p0), 128'(1));
    chk("t4_addr1", 128'(last_rd_addr), 128'(32'h0000_1100));
    load(32'h0000_1000);
    drain();
    chk("t4_miss2", 128'(rd_pulses - p0), 128'(2));
    chk("t4_addr2", 128'(last_rd_addr), 128'(32'h0000_1000));

    // Flush while idle invalidates a resident line
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    p0 = rd_pulses;
    load(32'h0000_1000);
    drain();
    chk("flush_idle_miss", 128'(rd_pulses - p0), 128'(1));

    // Flush during a fill is applied after it, so the filled line is invalid too
    p0 = rd_pulses;
    load(32'h0000_1050);
    @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    drain();
    chk("flush_fill_pulse", 128'(rd_pulses - p0), 128'(1));
    load(32'h0000_1050);
    drain();
    chk("flush_fill_refetch", 128'(rd_pulses - p0), 128'(2));

    // Simultaneous load and store: only the store happens
    wait_ready();
    p0 = rd_pulses;
    w0 = wr_pulses;
    bus.i_rd_en = 1'b1;
    bus.i_wr_en = 1'b1;
    bus.i_addr  = 32'h0000_1040;
    bus.i_wdata = 32'h1122_3344;
    bus.i_wstrb = 4'b1111;
    @(negedge clk);
    bus.i_rd_en = 1'b0;
    bus.i_wr_en = 1'b0;
    drain();
    chk("rdwr_wr_pulse", 128'(wr_pulses - w0), 128'(1));
    chk("rdwr_no_rd", 128'(rd_pulses - p0), 128'(0));
    chk("rdwr_addr", 128'(last_wr_addr), 128'(32'h0000_1040));

    // Controller held busy (calibration): miss waits with o_busy high
    cal_busy = 1'b1;
    repeat (50) @(negedge clk);
    chk("t5_idle_not_busy", 128'(bus.o_busy), 128'(0));
    p0 = rd_pulses;
    load(32'h0000_2000);
    for (int i = 0; i < 10; i++) begin
      chk("t5_busy_held", 128'(bus.o_busy), 128'(1));
      chk("t5_no_pulse", 128'(bus.o_dram_rd_en), 128'(0));
      @(negedge clk);
    end
    cal_busy = 1'b0;
    drain();
    chk("t5_pulse_after", 128'(rd_pulses - p0), 128'(1));
    chk("t5_addr", 128'(last_rd_addr), 128'(32'h0000_2000));

    // Make 0x1040 resident, then reset during a fill
    load(32'h0000_1040);
    drain();
    p0 = rd_pulses;
    load(32'h0000_1044);
    drain();
    chk("t6_pre_hit", 128'(rd_pulses - p0), 128'(0));
    load(32'h0000_3000);
    for (int i = 0; i < 50 && bus.o_dram_rd_en !== 1'b1; i++) @(negedge clk);
    chk("t6_pulse_seen", 128'(bus.o_dram_rd_en), 128'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", 128'(bus.o_busy), 128'(0));
    chk("t6_rst_rvalid", 128'(bus.o_rvalid), 128'(0));
    chk("t6_rst_rd_en", 128'(bus.o_dram_rd_en), 128'(0));
    chk("t6_rst_rdata", 128'(bus.o_rdata), 128'(0));
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    p0 = rd_pulses;
    load(32'h0000_1044);
    chk("t6_waits_ctl", 128'(bus.o_busy), 128'(1));
    drain();
    chk("t6_miss_after_rst", 128'(rd_pulses - p0), 128'(1));
    chk("t6_addr", 128'(last_rd_addr), 128'(32'h0000_1040));

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
